// File: rtl/issue_fu_stub.sv
// issue_fu_stub: functional-unit model fed by the issue stage. Accepts one
// instruction per cycle into an in-order queue and emits a one-cycle done pulse
// a fixed LATENCY after acceptance. Provides busy mask, counters, sticky dup_err.
// Latency: accept at edge E -> done registered at edge E+LATENCY.
// Backpressure: issue_ready low while queue holds DEPTH entries (registered only).
// Ports: clk/rst (async active-low); issue_valid/issue_wfid/issue_ready in;
//        done/done_wfid, wf_busy, inflight, accept_count, done_count, dup_err out.
module issue_fu_stub #(
  parameter int WFID_WIDTH = 6,
  parameter int LATENCY    = 4,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic [WFID_WIDTH-1:0]      issue_wfid,
  output logic                       issue_ready,
  output logic                       done,
  output logic [WFID_WIDTH-1:0]      done_wfid,
  output logic [2**WFID_WIDTH-1:0]   wf_busy,
  output logic [4:0]                 inflight,
  output logic [15:0]                accept_count,
  output logic [15:0]                done_count,
  output logic                       dup_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int NB = 2**WFID_WIDTH;

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [4:0]            r_count;
  logic [7:0]            r_cyc;
  logic [WFID_WIDTH-1:0] r_q_wfid  [DEPTH];
  logic [7:0]            r_q_stamp [DEPTH];
  logic                  r_done;
  logic [WFID_WIDTH-1:0] r_done_wfid;
  logic [NB-1:0]         r_busy;
  logic [15:0]           r_acc_cnt;
  logic [15:0]           r_done_cnt;
  logic                  r_dup;

  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;
  logic [7:0]            w_age;
  logic [WFID_WIDTH-1:0] w_head_wfid;
  logic [NB-1:0]         w_busy_nxt;

  // Ready depends on registered occupancy only; a pop at the same edge does
  // not open a slot for an accept.
  assign w_ready     = (r_count != 5'(DEPTH));
  assign w_push      = issue_valid && w_ready;
  assign w_head_wfid = r_q_wfid[r_rd_ptr];
  // Modulo-256 age keeps the comparison correct across counter wrap.
  assign w_age       = r_cyc - r_q_stamp[r_rd_ptr];
  assign w_pop       = (r_count != 5'd0) && (w_age == 8'(LATENCY));

  // Clear for the completing entry first, then set for the new accept so a
  // same-edge accept of the completing wfid leaves the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop)  w_busy_nxt[w_head_wfid] = 1'b0;
    if (w_push) w_busy_nxt[issue_wfid]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cyc       <= '0;
      r_done      <= 1'b0;
      r_done_wfid <= '0;
      r_busy      <= '0;
      r_acc_cnt   <= '0;
      r_done_cnt  <= '0;
      r_dup       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_wfid[i]  <= '0;
        r_q_stamp[i] <= '0;
      end
    end else begin
      r_cyc  <= r_cyc + 8'd1;
      r_busy <= w_busy_nxt;
      if (w_push) begin
        r_q_wfid[r_wr_ptr]  <= issue_wfid;
        r_q_stamp[r_wr_ptr] <= r_cyc;
        r_wr_ptr            <= r_wr_ptr + PW'(1);
        r_acc_cnt           <= r_acc_cnt + 16'd1;
        if (r_busy[issue_wfid]) r_dup <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PW'(1);
        r_done_cnt <= r_done_cnt + 16'd1;
      end
      r_done      <= w_pop;
      r_done_wfid <= w_pop ? w_head_wfid : '0;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign issue_ready  = w_ready;
  assign done         = r_done;
  assign done_wfid    = r_done_wfid;
  assign wf_busy      = r_busy;
  assign inflight     = r_count;
  assign accept_count = r_acc_cnt;
  assign done_count   = r_done_cnt;
  assign dup_err      = r_dup;

endmodule

// File: tb/tb_issue_fu_stub.sv
// tb_issue_fu_stub: directed checks of issue_fu_stub with DEPTH=4 and DEPTH=8
// instances (LATENCY=4) sharing clock and reset.
// Ports: none (top-level bench).
module tb_issue_fu_stub;

  logic        clk;
  logic        rst;

  logic        v4, v8;
  logic [5:0]  w4, w8;
  logic        rdy4, rdy8, done4, done8;
  logic [5:0]  dw4, dw8;
  logic [63:0] busy4, busy8;
  logic [4:0]  inf4, inf8;
  logic [15:0] ac4, ac8, dc4, dc8;
  logic        dup4, dup8;

  int n_tests;
  int n_fail;

  issue_fu_stub #(.WFID_WIDTH(6), .LATENCY(4), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .issue_valid(v4), .issue_wfid(w4), .issue_ready(rdy4),
    .done(done4), .done_wfid(dw4), .wf_busy(busy4), .inflight(inf4),
    .accept_count(ac4), .done_count(dc4), .dup_err(dup4)
  );

  issue_fu_stub #(.WFID_WIDTH(6), .LATENCY(4), .DEPTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .issue_valid(v8), .issue_wfid(w8), .issue_ready(rdy8),
    .done(done8), .done_wfid(dw8), .wf_busy(busy8), .inflight(inf8),
    .accept_count(ac8), .done_count(dc8), .dup_err(dup8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int  acc, seen, stalls, gaps, maxinf, first_low, lat, ndone;
  logic vv, rr;

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b0; v4 = 0; w4 = 0; v8 = 0; w8 = 0;

    // Reset values
    tick; tick;
    chk("rst_ready4", rdy4, 1);  chk("rst_ready8", rdy8, 1);
    chk("rst_done", done4, 0);   chk("rst_dwfid", dw4, 0);
    chk("rst_inflight", inf4, 0); chk("rst_busy", busy4, 0);
    chk("rst_acc", ac4, 0);      chk("rst_dcnt", dc4, 0);
    chk("rst_dup", dup4, 0);     chk("rst_busy8", busy8, 0);
    rst = 1'b1;

    // Single issue wfid=5
    v4 = 1; w4 = 6'd5;
    tick;                                   // edge E
    v4 = 0;
    chk("single_busy_E", busy4, 64'h20);
    chk("single_inf_E", inf4, 1);
    chk("single_acc_E", ac4, 1);
    tick; tick; tick;                       // E+3
    chk("single_nodone_E3", done4, 0);
    chk("single_busy_E3", busy4[5], 1);
    tick;                                   // E+4
    chk("single_done", done4, 1);
    chk("single_dwfid", dw4, 5);
    chk("single_busy_clr", busy4, 0);
    chk("single_dcnt", dc4, 1);
    chk("single_inf0", inf4, 0);
    tick;
    chk("single_pulse_end", done4, 0);
    chk("single_dwfid0", dw4, 0);

    // Back-to-back DEPTH=4: wfids 0..7 with valid held high
    acc = 0; seen = 0; stalls = 0; gaps = 0; maxinf = 0; first_low = -1;
    v4 = 1; w4 = 0;
    for (int c = 0; c < 40 && seen < 8; c++) begin
      vv = v4; rr = rdy4;
      tick;
      if (vv && rr) begin
        acc++;
        w4 = 6'(acc);
        if (acc == 8) v4 = 0;
      end else if (vv) stalls++;
      if (int'(inf4) > maxinf) maxinf = int'(inf4);
      if (done4) begin
        chk("b2b_order", dw4, 64'(seen));
        seen++;
      end else if (seen > 0 && seen < 8) gaps++;
      if (!rdy4 && first_low < 0) first_low = acc;
    end
    v4 = 0;
    chk("b2b_ndone", seen, 8);
    chk("b2b_ready_drop_at", first_low, 4);
    chk("b2b_stalls", stalls, 1);
    chk("b2b_gaps", gaps, 1);
    chk("b2b_maxinf", maxinf, 4);

    // Full rate DEPTH=8: 20 consecutive issues
    acc = 0; seen = 0; stalls = 0; gaps = 0; maxinf = 0;
    v8 = 1; w8 = 0;
    for (int c = 0; c < 60 && seen < 20; c++) begin
      vv = v8; rr = rdy8;
      tick;
      if (vv && rr) begin
        acc++;
        w8 = 6'(acc);
        if (acc == 20) v8 = 0;
      end else if (vv) stalls++;
      if (int'(inf8) > maxinf) maxinf = int'(inf8);
      if (done8) begin
        chk("full_order", dw8, 64'(seen));
        seen++;
      end else if (seen > 0 && seen < 20) gaps++;
    end
    v8 = 0;
    chk("full_ndone", seen, 20);
    chk("full_stalls", stalls, 0);
    chk("full_gaps", gaps, 0);
    chk("full_maxinf", maxinf, 4);
    chk("full_acc", ac8, 20);

    // Duplicate wfid=3 two cycles apart
    tick; tick;
    chk("dup_pre", dup4, 0);
    v4 = 1; w4 = 6'd3;
    tick;                                   // E
    v4 = 0;
    chk("dup_busy3", busy4[3], 1);
    chk("dup_not_yet", dup4, 0);
    tick;                                   // E+1
    v4 = 1; w4 = 6'd3;
    tick;                                   // E+2
    v4 = 0;
    chk("dup_set", dup4, 1);
    chk("dup_inf2", inf4, 2);
    tick;                                   // E+3
    chk("dup_nodone_E3", done4, 0);
    tick;                                   // E+4
    chk("dup_done1", done4, 1);
    chk("dup_dwfid1", dw4, 3);
    chk("dup_busy_clr", busy4[3], 0);
    tick;                                   // E+5
    chk("dup_nodone_E5", done4, 0);
    tick;                                   // E+6
    chk("dup_done2", done4, 1);
    chk("dup_dwfid2", dw4, 3);
    chk("dup_sticky", dup4, 1);

    // Wrap the 8-bit cycle counter: 60 isolated issues, 5 cycles each
    for (int i = 0; i < 60; i++) begin
      v4 = 1; w4 = 6'(i);
      tick;
      v4 = 0;
      lat = 0;
      do begin
        tick;
        lat++;
      end while (!done4 && lat < 10);
      chk("wrap_lat", lat, 4);
      chk("wrap_dwfid", dw4, 64'(i));
    end

    // Reset mid-flight with 3 entries queued
    v4 = 1; w4 = 6'd10; tick;
    w4 = 6'd11; tick;
    w4 = 6'd12; tick;
    v4 = 0;
    chk("mid_inf3", inf4, 3);
    #2 rst = 1'b0;
    #1;
    chk("mid_ready", rdy4, 1);   chk("mid_done", done4, 0);
    chk("mid_dwfid", dw4, 0);    chk("mid_busy", busy4, 0);
    chk("mid_inf", inf4, 0);     chk("mid_acc", ac4, 0);
    chk("mid_dcnt", dc4, 0);     chk("mid_dup", dup4, 0);
    tick; tick;
    rst = 1'b1;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (done4 || done8) ndone++;
    end
    chk("mid_no_done", ndone, 0);
    chk("mid_dcnt_after", dc4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_fu_stub.md
# issue_fu_stub

Bench-side functional-unit model that sits directly downstream of the issue stage under test, clocked and reset by the bench's clock/reset generator. It accepts issued instructions (one per cycle), keeps them in an in-order in-flight queue, and returns a one-cycle completion pulse carrying the wavefront id a fixed number of cycles after acceptance. It exposes back-pressure, a per-wavefront busy mask and sticky protocol-error flags so the bench's check tasks can compare issue behaviour against expected values.

## Interface
- WFID_WIDTH, 6, width of wavefront id; busy mask is 2**WFID_WIDTH bits
- LATENCY, 4, cycles from acceptance edge to completion; legal range 1..255
- DEPTH, 4, maximum instructions in flight; power of two, 2..16

- clk  in  1  bench clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- issue_valid  in  1  issue stage presents an instruction
- issue_wfid  in  WFID_WIDTH  wavefront id of presented instruction
- issue_ready  out  1  stub can accept this cycle
- done  out  1  one-cycle completion pulse
- done_wfid  out  WFID_WIDTH  id of completing instruction; 0 when done=0
- wf_busy  out  2**WFID_WIDTH  bit i set while wavefront i has an instruction in flight
- inflight  out  5  current queue occupancy
- accept_count  out  16  total accepts, wraps
- done_count  out  16  total completions, wraps
- dup_err  out  1  sticky: accepted a wfid whose busy bit was already set

## Operation
- Accept: at a rising edge where issue_valid=1 and issue_ready=1. Entry {wfid, timestamp} pushed at tail; wf_busy[wfid] set; accept_count+1.
- issue_ready = (inflight != DEPTH), driven from registered state only; no combinational path from issue_valid/issue_wfid.
- No accept into a full queue even if a pop occurs at the same edge.
- Completion: in-order. Head entry accepted at edge E completes at edge E+LATENCY: done=1, done_wfid=head wfid, entry popped, wf_busy[wfid] cleared, done_count+1. At most one completion per cycle; no back-pressure on done.
- Timestamps: free-running 8-bit cycle counter; age = (counter − stamp) mod 256; correct across wrap.
- Duplicate: accept with wf_busy[issue_wfid] already 1 → entry still enqueued, dup_err set, stays set until reset. Busy bit cleared at first completion of that wfid.
- Same-edge accept and completion of the same wfid: busy bit ends set (set wins).
- Same-edge accept and pop: inflight unchanged.

## Timing
- Reset (rst=0, immediate, asynchronous): issue_ready=1, done=0, done_wfid=0, wf_busy=0, inflight=0, accept_count=0, done_count=0, dup_err=0, queue and cycle counter cleared. Reset mid-operation discards all in-flight entries; no completion emitted for them.
- First edge with rst=1 may accept.
- Latency: issue_valid sampled high with ready at edge E → done high during cycle after edge E+LATENCY.
- Sustained one-per-cycle throughput only when DEPTH >= LATENCY+1; otherwise one idle cycle per DEPTH accepts.
- inflight, wf_busy, counters update at the same edge as the accept/pop causing them.

## Test plan
- Reset values: hold rst=0 two cycles → issue_ready=1, done=0, inflight=0, wf_busy=0, counters=0, dup_err=0.
- Single issue, LATENCY=4: wfid=5 accepted at edge E → done=1, done_wfid=5 exactly after edge E+4 for one cycle; wf_busy[5] high from E to E+4; accept_count=done_count=1.
- Back-to-back, DEPTH=4, LATENCY=4: issue_valid held high with wfids 0..7 → issue_ready drops after 4th accept; one bubble; dones in order 0..7, consecutive except one gap; inflight never exceeds 4.
- Full rate, DEPTH=8, LATENCY=4: 20 consecutive issues → issue_ready never low; 20 done pulses on 20 consecutive cycles; inflight peaks at 4.
- Duplicate: wfid=3 accepted twice, two cycles apart → dup_err=1 after second accept; two done pulses with wfid 3; wf_busy[3] clears after first done; dup_err stays 1.
- Reset mid-flight and wrap: run 300 cycles of issues to wrap cycle counter (latency still exactly 4), then assert rst with 3 in flight → outputs return to reset values asynchronously; no done pulses follow.
